// File: rtl/imem_reader_pkg.sv
// rtl/imem_reader_pkg.sv - shared constants and helpers for the instruction read front end
package imem_reader_pkg;

  // Instruction word presented by fetch before any real word has arrived (addi x0,x0,0)
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Default number of outstanding memory reads the reader tracks
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Memory bus is word addressed; low two address bits are forced to zero
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_reader_sync_fifo.sv
// rtl/imem_reader_sync_fifo.sv - in-order queue of outstanding request tags with occupancy count
module sync_fifo
  import imem_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  // Next-state: write at tail on push, advance head on pop; caller never pushes when full or pops when empty
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  // State registers; synchronous reset empties the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/imem_reader.sv
// rtl/imem_reader.sv - instruction memory read front end between fetch and the memory bus
module imem_reader
  import imem_reader_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic        MEM_WAIT,
  output logic        INST_RVALID,
  output logic [31:0] INST_ROADDR,
  output logic [31:0] INST_RDATA,
  output logic        MEM_RREQ,
  output logic [31:0] MEM_RADDR,
  input  logic        MEM_RREADY,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] occ;
  logic [31:0]   head_addr;
  logic          full;
  logic          push;
  logic          pop;
  logic          fwd;

  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          inst_rvalid_q, inst_rvalid_d;
  logic [31:0]   inst_roaddr_q, inst_roaddr_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;

  // Full is taken from registered occupancy so MEM_WAIT never sees INST_RDEN (fetch builds RDEN from WAIT)
  assign full      = (occ == CW'(DEPTH));
  assign MEM_WAIT  = RST | full | ~MEM_RREADY;
  assign MEM_RREQ  = INST_RDEN & ~full & ~FLUSH & ~RST;
  assign MEM_RADDR = word_align(INST_RIADDR);

  // A response with nothing outstanding is a bus error and is simply ignored
  assign push = MEM_RREQ & MEM_RREADY;
  assign pop  = MEM_RVALID & (occ != '0);
  assign fwd  = pop & (drop_cnt_q == '0) & ~FLUSH;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (INST_RIADDR),
    .head  (head_addr),
    .count (occ)
  );

  // Drop counter: a flush marks every still-outstanding request stale; stale responses count it down
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (FLUSH) begin
      drop_cnt_d = occ - CW'(pop);
    end else if (pop && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Output word: one-cycle valid pulse per forwarded response, address/data hold otherwise
  always_comb begin
    inst_rvalid_d = 1'b0;
    inst_roaddr_d = inst_roaddr_q;
    inst_rdata_d  = inst_rdata_q;
    if (fwd) begin
      inst_rvalid_d = 1'b1;
      inst_roaddr_d = head_addr;
      inst_rdata_d  = MEM_RDATA;
    end
  end

  // Registers for drop counter and fetch-facing outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q    <= '0;
      inst_rvalid_q <= 1'b0;
      inst_roaddr_q <= 32'h0000_0000;
      inst_rdata_q  <= NOP_INST;
    end else begin
      drop_cnt_q    <= drop_cnt_d;
      inst_rvalid_q <= inst_rvalid_d;
      inst_roaddr_q <= inst_roaddr_d;
      inst_rdata_q  <= inst_rdata_d;
    end
  end

  assign INST_RVALID = inst_rvalid_q;
  assign INST_ROADDR = inst_roaddr_q;
  assign INST_RDATA  = inst_rdata_q;

endmodule

// File: tb/tb_imem_reader.sv
// tb/tb_imem_reader.sv - scoreboard bench for imem_reader with an in-order latency memory model
module tb_imem_reader;

  logic        CLK;
  logic        RST;
  logic        FLUSH;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic        MEM_WAIT;
  logic        INST_RVALID;
  logic [31:0] INST_ROADDR;
  logic [31:0] INST_RDATA;
  logic        MEM_RREQ;
  logic [31:0] MEM_RADDR;
  logic        MEM_RREADY;
  logic        MEM_RVALID;
  logic [31:0] MEM_RDATA;

  logic mem_v;
  logic spur_v;
  assign MEM_RVALID = mem_v | spur_v;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mem_k    = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mreq_q[$];

  imem_reader #(.DEPTH(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FLUSH       (FLUSH),
    .INST_RDEN   (INST_RDEN),
    .INST_RIADDR (INST_RIADDR),
    .MEM_WAIT    (MEM_WAIT),
    .INST_RVALID (INST_RVALID),
    .INST_ROADDR (INST_ROADDR),
    .INST_RDATA  (INST_RDATA),
    .MEM_RREQ    (MEM_RREQ),
    .MEM_RADDR   (MEM_RADDR),
    .MEM_RREADY  (MEM_RREADY),
    .MEM_RVALID  (MEM_RVALID),
    .MEM_RDATA   (MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Memory model: accepts on RREQ&RREADY, answers in order after mem_k cycles
  initial begin
    logic        s_rst, s_acc, s_cons;
    logic [31:0] s_addr;
    int          s_cyc;
    mreq_t       m;
    mem_v     = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      s_rst  = RST;
      s_acc  = MEM_RREQ && MEM_RREADY;
      s_addr = MEM_RADDR;
      s_cons = mem_v;
      s_cyc  = cyc;
      @(posedge CLK);
      #1;
      if (s_rst) begin
        mreq_q.delete();
      end else begin
        if (s_cons && mreq_q.size() > 0) m = mreq_q.pop_front();
        if (s_acc) mreq_q.push_back('{s_addr, s_cyc + mem_k});
      end
      if (mreq_q.size() > 0 && mreq_q[0].due <= cyc) begin
        mem_v     = 1'b1;
        MEM_RDATA = word(mreq_q[0].addr);
      end else begin
        mem_v = 1'b0;
      end
    end
  end

  // Monitor: every forwarded word must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && INST_RVALID) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid actual addr=%h data=%h cyc=%0d required no word", INST_ROADDR, INST_RDATA, cyc);
        end else begin
          e = exp_q.pop_front();
          if (INST_ROADDR !== e.addr || INST_RDATA !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
            failures++;
            $display("FAIL rvalid_word actual addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                     INST_ROADDR, INST_RDATA, cyc, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  // Issue one request; if expect_fwd the returned word is expected at accept+k+1
  task automatic req(input logic [31:0] a, input bit expect_fwd);
    int n;
    bit done;
    INST_RDEN   = 1'b1;
    INST_RIADDR = a;
    done        = 1'b0;
    n           = 0;
    while (!done && n < 40) begin
      @(negedge CLK);
      if (MEM_RREQ && MEM_RREADY) begin
        done = 1'b1;
        chk("mem_raddr", MEM_RADDR, a & 32'hFFFF_FFFC);
        if (expect_fwd) exp_q.push_back('{a, word(a & 32'hFFFF_FFFC), cyc + mem_k + 1});
      end
      step();
      n++;
    end
    INST_RDEN = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual=not_accepted required=accepted addr=%h", a);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 80) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST         = 1'b1;
    FLUSH       = 1'b0;
    INST_RDEN   = 1'b1;
    INST_RIADDR = 32'h2000_0000;
    MEM_RREADY  = 1'b1;
    spur_v      = 1'b0;

    // Reset values, with a request pending to show it is blocked
    repeat (3) step();
    chk("rst_rvalid", 32'(INST_RVALID), 32'd0);
    chk("rst_rdata", INST_RDATA, 32'h0000_0013);
    chk("rst_roaddr", INST_ROADDR, 32'h0000_0000);
    chk("rst_mem_wait", 32'(MEM_WAIT), 32'd1);
    chk("rst_mem_rreq", 32'(MEM_RREQ), 32'd0);
    RST       = 1'b0;
    INST_RDEN = 1'b0;
    @(negedge CLK);
    chk("post_rst_mem_wait", 32'(MEM_WAIT), 32'd0);
    step();

    // Streaming, k=2: three consecutive words starting 3 cycles after the first request
    mem_k = 2;
    req(32'h2000_0000, 1'b1);
    req(32'h2000_0004, 1'b1);
    req(32'h2000_0008, 1'b1);
    drain();

    // Backpressure, k=10: four accepted, then stall until the first pop
    mem_k = 10;
    req(32'h2000_0200, 1'b1);
    req(32'h2000_0204, 1'b1);
    req(32'h2000_0208, 1'b1);
    req(32'h2000_020C, 1'b1);
    INST_RDEN   = 1'b1;
    INST_RIADDR = 32'h2000_0210;
    @(negedge CLK);
    chk("bp_full_wait", 32'(MEM_WAIT), 32'd1);
    chk("bp_full_rreq", 32'(MEM_RREQ), 32'd0);
    repeat (6) step();
    @(negedge CLK);
    chk("bp_wait_in_pop_cycle", 32'(MEM_WAIT), 32'd1);
    step();
    chk("bp_wait_after_pop", 32'(MEM_WAIT), 32'd0);
    req(32'h2000_0210, 1'b1);
    drain();

    // Flush with 3 outstanding; the oldest response lands in the flush cycle
    mem_k = 3;
    req(32'h2000_0300, 1'b0);
    req(32'h2000_0304, 1'b0);
    req(32'h2000_0308, 1'b0);
    FLUSH       = 1'b1;
    INST_RDEN   = 1'b1;
    INST_RIADDR = 32'h2000_0100;
    @(negedge CLK);
    chk("flush_no_rreq", 32'(MEM_RREQ), 32'd0);
    step();
    FLUSH = 1'b0;
    chk("flush_drop_2", 32'(dut.drop_cnt_q), 32'd2);
    req(32'h2000_0100, 1'b1);
    chk("flush_drop_1", 32'(dut.drop_cnt_q), 32'd1);
    step();
    chk("flush_drop_0", 32'(dut.drop_cnt_q), 32'd0);
    drain();

    // Back-to-back flushes two cycles apart
    mem_k = 4;
    req(32'h2000_0400, 1'b0);
    req(32'h2000_0404, 1'b0);
    req(32'h2000_0408, 1'b0);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("b2b_drop_3", 32'(dut.drop_cnt_q), 32'd3);
    req(32'h2000_040C, 1'b0);
    chk("b2b_drop_2a", 32'(dut.drop_cnt_q), 32'd2);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("b2b_drop_2b", 32'(dut.drop_cnt_q), 32'd2);
    req(32'h2000_0500, 1'b1);
    chk("b2b_drop_1a", 32'(dut.drop_cnt_q), 32'd1);
    step();
    chk("b2b_drop_1b", 32'(dut.drop_cnt_q), 32'd1);
    step();
    chk("b2b_drop_0", 32'(dut.drop_cnt_q), 32'd0);
    drain();

    // Misaligned fetch address: bus sees word address, fetch sees original
    mem_k = 1;
    req(32'h2000_0006, 1'b1);
    drain();

    // Response with nothing outstanding must be ignored
    spur_v = 1'b1;
    step();
    spur_v = 1'b0;
    step();
    mem_k = 2;
    req(32'h2000_0040, 1'b1);
    req(32'h2000_0044, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_reader.md
# imem_reader

Instruction-side read front end directly upstream of the fetch stage. It accepts the fetch stage's per-cycle read request (`INST_RDEN`/`INST_RIADDR`) and issues it to the instruction memory bus. It tracks outstanding addresses in an in-order queue and returns each word with its address to fetch (`INST_RVALID`/`INST_ROADDR`/`INST_RDATA`). On pipeline flush it discards responses to requests issued before the flush.

## Interface
- `DEPTH`, default 4: maximum outstanding requests; power of two, ≥2.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `FLUSH`  in  1  pipeline flush; the same signal the fetch stage receives.
- `INST_RDEN`  in  1  fetch requests a read this cycle.
- `INST_RIADDR`  in  32  fetch PC.
- `MEM_WAIT`  out  1  request cannot be accepted this cycle; fetch holds its PC.
- `INST_RVALID`  out  1  instruction word valid this cycle.
- `INST_ROADDR`  out  32  address of the returned word.
- `INST_RDATA`  out  32  returned instruction word.
- `MEM_RREQ`  out  1  read request to memory.
- `MEM_RADDR`  out  32  request address, word aligned.
- `MEM_RREADY`  in  1  memory accepts a request this cycle; must not depend on `MEM_RREQ`.
- `MEM_RVALID`  in  1  read response valid; responses return in request order.
- `MEM_RDATA`  in  32  response data.

## Operation
- Request path is combinational:
  - `full` = occupancy == DEPTH, computed from registered occupancy.
  - `MEM_WAIT` = RST | full | !MEM_RREADY.
  - `MEM_WAIT` must not depend on `INST_RDEN`. Fetch derives `INST_RDEN` from `MEM_WAIT`, so a dependency would form a combinational loop.
  - `MEM_RREQ` = INST_RDEN & !full & !FLUSH & !RST.
  - `MEM_RADDR` = {INST_RIADDR[31:2], 2'b00}.
- Accept (push) = MEM_RREQ & MEM_RREADY. The queue stores the full 32-bit `INST_RIADDR`.
- Response (pop) = MEM_RVALID & occupancy != 0. A `MEM_RVALID` while the queue is empty is a protocol violation and is ignored with no state change.
- Forward condition = pop & drop_cnt == 0 & !FLUSH. The registered outputs take {1, head addr, MEM_RDATA}. Otherwise next `INST_RVALID` = 0 and `INST_ROADDR`/`INST_RDATA` hold their values.
- Drop counter, width log2(DEPTH)+1:
  - On FLUSH: drop_cnt <= occupancy − pop. This covers all stale in-flight requests, and no push occurs in a FLUSH cycle.
  - Otherwise, pop & drop_cnt != 0: decrement.
  - Repeated flushes recompute the counter; stale entries are never double counted.
- Occupancy update: +push −pop. Push and pop in the same cycle is allowed when not full.
- Reset values: queue empty, drop_cnt 0, `INST_RVALID` 0, `INST_ROADDR` 0x0000_0000, `INST_RDATA` 0x0000_0013 (NOP). During reset: `MEM_WAIT` 1, `MEM_RREQ` 0.
- Reset mid-operation: outstanding memory responses arriving after reset deassertion are the system's responsibility. The memory bus is reset by the same `RST`.

## Timing
- Request accepted in cycle t; memory responds at t+k (k ≥ 1); `INST_RVALID` is high in cycle t+k+1.
- Full throughput (one word per cycle) when DEPTH ≥ k+1.
- When full, the cycle's request stalls even if a pop occurs in the same cycle. `MEM_WAIT` rises the cycle after occupancy reaches DEPTH and falls the cycle after a pop.
- FLUSH at cycle t:
  - No request is issued at t.
  - A response arriving at t is dropped.
  - Requests issued at t+1 and later are forwarded normally once the old responses have drained.
- `INST_RVALID` is a one-cycle pulse per forwarded word. It is not held while fetch stalls, because fetch caches the word itself.

## Structure
- Shared package constant: `NOP_INST` = 32'h0000_0013. Use it in both this block and the fetch stage.
- Sub-module `sync_fifo`:
  - Parameters: width 32, `DEPTH`.
  - Signals: push/pop, head output, occupancy output.
  - Reusable for the data-side reader.
- The drop counter and output registers live in `imem_reader`.

## Test plan
- Reset: RST 3 cycles → `INST_RVALID`=0, `INST_RDATA`=0x00000013, `MEM_WAIT`=1, `MEM_RREQ`=0. The cycle after release, `MEM_WAIT`=0 with `MEM_RREADY`=1.
- Streaming, k=2, DEPTH=4: requests 0x2000_0000, 0x2000_0004, 0x2000_0008 on consecutive cycles → `INST_RVALID` for three consecutive cycles starting 3 cycles after the first request, with `INST_ROADDR` matching each address.
- Backpressure: memory withholds responses with k=10 → four requests are accepted, then `MEM_WAIT`=1 and `MEM_RREQ`=0. The first response pops an entry, and `MEM_WAIT`=0 the next cycle.
- Flush with 3 outstanding, including a response arriving in the FLUSH cycle → none of the old words appear on `INST_RVALID`. The first post-flush request (0x2000_0100) returns with `INST_ROADDR`=0x2000_0100.
- Back-to-back flushes 2 cycles apart with outstanding requests → all pre-second-flush responses are dropped, and drop_cnt reaches 0 exactly when the last stale response pops.
- Misaligned `INST_RIADDR` 0x2000_0006 → `MEM_RADDR`=0x2000_0004, and `INST_ROADDR`=0x2000_0006.
